// File: rtl/usi_pkg.sv
// Shared types and constants for the USI transmit path.
package usi_pkg;

   localparam int   USI_BYTE_W        = 8;
   localparam logic USI_TX_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } usi_tx_state_t;

endpackage

// File: rtl/usi_baud_counter.sv
// Bit-period counter: counts 0..period-1 and pulses tick on the last count.
// A period of 0 behaves as a period of 1.
module usi_baud_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clear,
   input  logic [CNT_W-1:0] period,
   output logic             tick
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] last_cnt;

   always_comb begin
      last_cnt = (period == '0) ? '0 : period - CNT_W'(1);
      tick     = (count_q == last_cnt);
      count_d  = (clear || tick) ? '0 : count_q + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/usi_tx_serializer.sv
// USI transmit serializer: pops bytes from the buffer and frames them onto tx.
// Optional parity bit and parity_odd port are built with USI_TX_PARITY_EN.
//
// state     | meaning
// ST_IDLE   | line idle high, waiting for enable and a non-empty buffer
// ST_START  | start bit (low) for one bit period
// ST_DATA   | 8 data bits, LSB first
// ST_PARITY | parity bit (USI_TX_PARITY_EN only)
// ST_STOP   | 1 or 2 stop bits (high); may chain straight into the next frame
module usi_tx_serializer
   import usi_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  enable,
   input  logic [CNT_W-1:0]      clks_per_bit,
   input  logic                  stop_bits_2,
`ifdef USI_TX_PARITY_EN
   input  logic                  parity_odd,
`endif
   input  logic [7:0]            buffer_occupancy,
   input  logic [USI_BYTE_W-1:0] data_out,
   output logic                  send,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done,
   output logic [15:0]           frames_sent
);

   usi_tx_state_t         state_q, state_d;
   logic [USI_BYTE_W-1:0] shift_q, shift_d;
   logic [2:0]            bit_idx_q, bit_idx_d;
   logic                  stop_idx_q, stop_idx_d;
   logic                  par_q, par_d;
   logic [CNT_W-1:0]      cpb_q, cpb_d;
   logic                  stop2_q, stop2_d;
   logic                  tx_q, tx_d;
   logic [15:0]           frames_q, frames_d;
`ifdef USI_TX_PARITY_EN
   logic                  odd_q, odd_d;
`endif

   logic fetch;
   logic load;
   logic send_c;
   logic done_c;
   logic tick;
   logic cnt_clear;

   assign fetch = enable && (buffer_occupancy != 8'd0);

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      par_d      = par_q;
      cpb_d      = cpb_q;
      stop2_d    = stop2_q;
      frames_d   = frames_q;
`ifdef USI_TX_PARITY_EN
      odd_d      = odd_q;
`endif
      load       = 1'b0;
      send_c     = 1'b0;
      done_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fetch) begin
               load = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               par_d     = par_q ^ shift_q[0];
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  stop_idx_d = 1'b0;
`ifdef USI_TX_PARITY_EN
                  state_d    = ST_PARITY;
`else
                  state_d    = ST_STOP;
`endif
               end
            end
         end
`ifdef USI_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_d    = ST_STOP;
               stop_idx_d = 1'b0;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (stop2_q && !stop_idx_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  done_c   = 1'b1;
                  frames_d = frames_q + 16'd1;
                  if (fetch) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Fetch from idle and back-to-back fetch from the last stop cycle share this path.
      if (load) begin
         send_c     = 1'b1;
         shift_d    = data_out;
         par_d      = 1'b0;
         bit_idx_d  = 3'd0;
         stop_idx_d = 1'b0;
         cpb_d      = clks_per_bit;
         stop2_d    = stop_bits_2;
`ifdef USI_TX_PARITY_EN
         odd_d      = parity_odd;
`endif
         state_d    = ST_START;
      end

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef USI_TX_PARITY_EN
         ST_PARITY: tx_d = par_d ^ odd_d;
`endif
         default:   tx_d = USI_TX_IDLE_LEVEL;
      endcase
   end

   assign cnt_clear = (state_d != state_q) || (state_q == ST_IDLE);

   usi_baud_counter #(
      .CNT_W (CNT_W)
   ) u_baud (
      .CLK    (CLK),
      .RST    (RST),
      .clear  (cnt_clear),
      .period (cpb_q),
      .tick   (tick)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= 3'd0;
         stop_idx_q <= 1'b0;
         par_q      <= 1'b0;
         cpb_q      <= '0;
         stop2_q    <= 1'b0;
         tx_q       <= USI_TX_IDLE_LEVEL;
         frames_q   <= 16'd0;
`ifdef USI_TX_PARITY_EN
         odd_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         par_q      <= par_d;
         cpb_q      <= cpb_d;
         stop2_q    <= stop2_d;
         tx_q       <= tx_d;
         frames_q   <= frames_d;
`ifdef USI_TX_PARITY_EN
         odd_q      <= odd_d;
`endif
      end
   end

   assign send        = send_c;
   assign frame_done  = done_c;
   assign busy        = (state_q != ST_IDLE);
   assign tx          = tx_q;
   assign frames_sent = frames_q;

endmodule

// File: tb/tb_usi_tx_serializer.sv
// Directed bench for usi_tx_serializer: single-frame vector table plus
// multi-frame sequences (back-to-back, period change, enable drop, reset).
module tb_usi_tx_serializer;

`ifdef USI_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        enable;
   logic [15:0] clks_per_bit;
   logic        stop_bits_2;
`ifdef USI_TX_PARITY_EN
   logic        parity_odd;
`endif
   logic [7:0]  buffer_occupancy;
   logic [7:0]  data_out;
   logic        send;
   logic        tx;
   logic        busy;
   logic        frame_done;
   logic [15:0] frames_sent;

   int total = 0;
   int bad = 0;
   int exp_frames = 0;

   always #5 CLK = ~CLK;

   usi_tx_serializer #(.CNT_W(16)) dut (
      .CLK              (CLK),
      .RST              (RST),
      .enable           (enable),
      .clks_per_bit     (clks_per_bit),
      .stop_bits_2      (stop_bits_2),
`ifdef USI_TX_PARITY_EN
      .parity_odd       (parity_odd),
`endif
      .buffer_occupancy (buffer_occupancy),
      .data_out         (data_out),
      .send             (send),
      .tx               (tx),
      .busy             (busy),
      .frame_done       (frame_done),
      .frames_sent      (frames_sent)
   );

   typedef struct {
      logic [7:0] data;
      int         cpb;
      logic       s2;
      logic       odd;
      int         peff;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line level for bit k of a frame: start, 8 data LSB first, [parity], stops.
   function automatic logic fbit(input logic [7:0] b, input logic odd, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (PB == 1 && k == 9) return (^b) ^ odd;
      return 1'b1;
   endfunction

   task automatic run_stream(input string name, input int navail, input int nexp,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int cpb0, input int cpb_new, input int chg_cyc, input int en_drop,
                             input int p0, input int p1, input int p2,
                             input logic s2, input logic odd);
      logic [7:0] bytes [3];
      int pe [3];
      int len [3];
      int start [3];
      int ncyc, idx, sidx, f, k;
      logic exp_send;
      bytes = '{b0, b1, b2};
      pe    = '{p0, p1, p2};
      ncyc  = 1;
      for (int i = 0; i < 3; i++) begin
         len[i]   = (10 + PB + (s2 ? 1 : 0)) * pe[i];
         start[i] = ncyc;
         if (i < nexp) ncyc += len[i];
      end
      ncyc += 4;
      idx  = 0;
      sidx = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge CLK); #1;
         enable           = (en_drop < 0) || (c < en_drop);
         clks_per_bit     = (chg_cyc >= 0 && c >= chg_cyc) ? 16'(cpb_new) : 16'(cpb0);
         stop_bits_2      = s2;
`ifdef USI_TX_PARITY_EN
         parity_odd       = odd;
`endif
         data_out         = bytes[(idx < 3) ? idx : 2];
         buffer_occupancy = (idx < navail) ? 8'(navail - idx) : 8'd0;
         @(negedge CLK);
         exp_send = (sidx < nexp) && (c == start[sidx] - 1);
         chk({name, " send"}, 32'(send), 32'(exp_send));
         if (send) idx++;
         if (exp_send) sidx++;
         f = -1;
         for (int i = 0; i < nexp; i++)
            if (c >= start[i] && c < start[i] + len[i]) f = i;
         if (f >= 0) begin
            k = (c - start[f]) / pe[f];
            chk({name, " tx"}, 32'(tx), 32'(fbit(bytes[f], odd, k)));
            chk({name, " frame_done"}, 32'(frame_done), 32'(c == start[f] + len[f] - 1));
            chk({name, " busy"}, 32'(busy), 32'd1);
         end else begin
            chk({name, " idle tx"}, 32'(tx), 32'd1);
            chk({name, " idle frame_done"}, 32'(frame_done), 32'd0);
            if (!exp_send) chk({name, " idle busy"}, 32'(busy), 32'd0);
         end
      end
      exp_frames += nexp;
      chk({name, " frames_sent"}, 32'(frames_sent), 32'(exp_frames));
      buffer_occupancy = 8'd0;
      enable = 1'b1;
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = '{data: 8'hA5, cpb: 4, s2: 1'b0, odd: 1'b0, peff: 4};
      vecs[1] = '{data: 8'h3C, cpb: 2, s2: 1'b1, odd: 1'b0, peff: 2};
      vecs[2] = '{data: 8'h00, cpb: 0, s2: 1'b0, odd: 1'b0, peff: 1};
      vecs[3] = '{data: 8'hFF, cpb: 1, s2: 1'b1, odd: 1'b1, peff: 1};
      vecs[4] = '{data: 8'h03, cpb: 2, s2: 1'b1, odd: 1'b1, peff: 2};
      vecs[5] = '{data: 8'h03, cpb: 2, s2: 1'b1, odd: 1'b0, peff: 2};

      RST              = 1'b1;
      enable           = 1'b0;
      clks_per_bit     = 16'd4;
      stop_bits_2      = 1'b0;
`ifdef USI_TX_PARITY_EN
      parity_odd       = 1'b0;
`endif
      buffer_occupancy = 8'd0;
      data_out         = 8'd0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset tx", 32'(tx), 32'd1);
      chk("reset send", 32'(send), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      chk("reset frames_sent", 32'(frames_sent), 32'd0);
      RST    = 1'b0;
      enable = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("empty buffer send", 32'(send), 32'd0);

      for (int v = 0; v < 6; v++)
         run_stream($sformatf("vec%0d", v), 1, 1, vecs[v].data, 8'h00, 8'h00,
                    vecs[v].cpb, 0, -1, -1, vecs[v].peff, 1, 1, vecs[v].s2, vecs[v].odd);

      run_stream("b2b", 3, 3, 8'h00, 8'hFF, 8'h55, 2, 0, -1, -1, 2, 2, 2, 1'b0, 1'b0);
      run_stream("cpb_chg", 2, 2, 8'h5A, 8'hC3, 8'h00, 4, 8, 10, -1, 4, 8, 1, 1'b0, 1'b1);
      run_stream("en_drop", 2, 1, 8'h33, 8'h44, 8'h00, 4, 0, -1, 15, 4, 1, 1, 1'b0, 1'b0);

      // Reset during data bit 3 (cycles 17..20 after the fetch at cycle 0, P=4).
      for (int c = 0; c < 18; c++) begin
         @(posedge CLK); #1;
         enable           = 1'b1;
         clks_per_bit     = 16'd4;
         stop_bits_2      = 1'b0;
         data_out         = 8'hA5;
         buffer_occupancy = (c == 0) ? 8'd1 : 8'd0;
         @(negedge CLK);
         if (c == 17) begin
            chk("rst pre tx bit3", 32'(tx), 32'd0);
            chk("rst pre busy", 32'(busy), 32'd1);
         end
      end
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rst tx", 32'(tx), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst frames_sent", 32'(frames_sent), 32'd0);
      chk("rst frame_done", 32'(frame_done), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge CLK);
         chk("post rst tx", 32'(tx), 32'd1);
         chk("post rst frame_done", 32'(frame_done), 32'd0);
         chk("post rst send", 32'(send), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
